// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package muldiv_pkg;

   // Operation codes presented on the op port
   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   // Control FSM state encodings
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   // Iteration counter must be able to hold the value WIDTH
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module muldiv_div_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] part;
   logic [WIDTH:0] trial;

   // rem_in < divisor, so the shifted partial fits WIDTH+1 bits and the trial's MSB is the borrow
   always_comb begin
      part    = {rem_in, bit_in};
      trial   = part - {1'b0, divisor};
      q_bit   = ~trial[WIDTH];
      rem_out = q_bit ? trial[WIDTH-1:0] : part[WIDTH-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// Shared iterative MULT/MULTU/DIV/DIVU engine writing HI/LO; optional MULDIV_EARLY_OUT_EN ends multiplies early.
// Latency: done in the cycle after edge E0+WIDTH+1 (E0+1 for divide by zero); data-dependent multiplies with early-out.
// Backpressure: one op at a time; start is ignored whenever busy is high (including the done cycle).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = cnt_width(WIDTH);

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic               div_q;
   logic               neg_res;
   logic               neg_rem;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   dsor;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   rem_nxt;
   logic               q_bit;
   logic               is_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               last_iter;

   // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned
   always_comb begin
      is_signed = (op == OP_MULT) || (op == OP_DIV);
      a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
      b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
   end

   // Decide whether this CALC cycle is the final iteration
   always_comb begin
      last_iter = (cnt == CW'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
      // Multiplicand is pre-shifted, so stopping once the multiplier is exhausted keeps the product exact
      if (!div_q && (mplier[WIDTH-1:1] == '0)) begin
         last_iter = 1'b1;
      end
`endif
   end

   // Dividend bits leave mplier MSB-first while quotient bits enter at the LSB
   muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (rem),
      .bit_in  (mplier[WIDTH-1]),
      .divisor (dsor),
      .rem_out (rem_nxt),
      .q_bit   (q_bit)
   );

   // busy covers the whole operation including the done cycle
   assign busy = (state != S_IDLE) || done;

   // Control FSM, datapath iteration and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         div_q    <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         dsor     <= '0;
         rem      <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && !done) begin
                  div_q   <= op[1];
                  neg_res <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_rem <= is_signed && a[WIDTH-1];
                  cnt     <= '0;
                  acc     <= '0;
                  rem     <= '0;
                  mcand   <= {{WIDTH{1'b0}}, a_mag};
                  mplier  <= op[1] ? a_mag : b_mag;
                  dsor    <= b_mag;
                  state   <= (op[1] && (b == '0)) ? S_FIN : S_CALC;
               end
            end
            S_CALC: begin
               if (!div_q) begin
                  if (mplier[0]) begin
                     acc <= acc + mcand;
                  end
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end else begin
                  rem    <= rem_nxt;
                  mplier <= {mplier[WIDTH-2:0], q_bit};
               end
               cnt <= cnt + 1'b1;
               if (last_iter) begin
                  state <= S_FIN;
               end
            end
            S_FIN: begin
               done <= 1'b1;
               if (div_q && (dsor == '0)) begin
                  // Divide by zero: report only, HI/LO keep the previous result
                  div_zero <= 1'b1;
               end else if (div_q) begin
                  lo <= neg_res ? -mplier : mplier;
                  hi <= neg_rem ? -rem : rem;
               end else begin
                  {hi, lo} <= neg_res ? -acc : acc;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op = 2'd0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           at_edge;
      string        name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected edges from acceptance to the edge that raises done
   function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] bb);
      if (o[1]) return (bb == '0) ? 1 : W + 1;
`ifdef MULDIV_EARLY_OUT_EN
      begin
         logic [W-1:0] m;
         int n;
         m = (o == 2'd0 && bb[W-1]) ? -bb : bb;
         n = 1;
         for (int i = 0; i < W; i++) if (m[i]) n = i + 1;
         return n + 1;
      end
`else
      return W + 1;
`endif
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got hi=%h lo=%h dz=%b, required no done", hi, lo, div_zero);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_hi"}, 64'(hi), 64'(mon_e.hi));
            chk({mon_e.name, "_lo"}, 64'(lo), 64'(mon_e.lo));
            chk({mon_e.name, "_dz"}, 64'(div_zero), 64'(mon_e.dz));
            chk({mon_e.name, "_lat"}, 64'(edge_cnt), 64'(mon_e.at_edge));
            chk({mon_e.name, "_busy"}, 64'(busy), 64'd1);
         end
      end
   end

   task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edz, input bit expect_it);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      a     = aa;
      b     = bb;
      if (expect_it)
         sb.push_back('{hi: ehi, lo: elo, dz: edz, at_edge: edge_cnt + 1 + exp_lat(o, bb), name: name});
      @(negedge clk);
      start = 1'b0;
      op    = 2'd0;
      a     = '0;
      b     = '0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done within 200 cycles, required done", name);
      end
   endtask

   task automatic run(input string name, input logic [1:0] o, input logic [W-1:0] aa,
                      input logic [W-1:0] bb, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                      input logic edz);
      issue(name, o, aa, bb, ehi, elo, edz, 1'b1);
      wait_done(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_dz",   64'(div_zero), 64'd0);
      chk("rst_hi",   64'(hi), 64'd0);
      chk("rst_lo",   64'(lo), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);

      // Directed vectors: op, a, b, expected hi, expected lo, expected div_zero
      run("multu_max",  2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run("mult_m3x7",  2'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      run("multu_m3x7", 2'd1, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB, 1'b0);
      run("multu_9x1",  2'd1, 32'h00000009, 32'h00000001, 32'h00000000, 32'h00000009, 1'b0);
      run("mult_mnsq",  2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      run("mult_m1m1",  2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
      run("div_m7d2",   2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run("div_7dm2",   2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      run("divu_100d7", 2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
      run("div_mnm1",   2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      run("divu_5d0",   2'd3, 32'd5,        32'd0,        32'h00000000, 32'h80000000, 1'b1);
      run("div_m100d7", 2'd2, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0);

      // start while busy must be ignored and the original result delivered
      issue("ign_start", 2'd1, 32'h12345678, 32'h80000010, 32'h091A2B3D, 32'h23456780, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      chk("ign_busy", 64'(busy), 64'd1);
      start = 1'b1;
      op    = 2'd3;
      a     = 32'd5;
      b     = 32'd0;
      @(negedge clk);
      start = 1'b0;
      wait_done("ign_start");

      // Reset mid-CALC: clears results and no done may follow
      issue("rst_mid", 2'd1, 32'h0000AAAA, 32'h80000001, 32'h0, 32'h0, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      chk("mid_busy_pre", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_done", 64'(done), 64'd0);
      chk("mid_hi",   64'(hi), 64'd0);
      chk("mid_lo",   64'(lo), 64'd0);
      reset = 1'b0;
      repeat (45) @(negedge clk);

      // Scoreboard must be drained
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
